cram_palette_fetch: RTL and testbench

CRAM_PALETTE_FETCH -- requirements
Module: cram_palette_fetch

---
 rtl/cram_palette_fetch.sv | 227 ++++++++++++++++++++++
 tb/tb_cram_palette_fetch.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cram_palette_fetch.sv
// Palette fetch engine: time-shares an external 8-bit colour RAM between two-byte
// pixel palette reads and single-byte CPU writes, with a one-entry pixel pending slot.
module cram_palette_fetch (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_ce,
  input  logic [7:0] color_idx,
  input  logic       blank,
  input  logic       cpu_req,
  input  logic [8:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_ack,
  output logic [8:0] cram_addr,
  output logic       cram_cen,
  output logic       cram_oen,
  output logic       cram_wen,
  input  logic [7:0] cram_din,
  output logic [7:0] cram_dout,
  output logic       cram_dout_en,
  output logic [4:0] rgb_r,
  output logic [4:0] rgb_g,
  output logic [4:0] rgb_b,
  output logic       rgb_valid,
  output logic       overrun
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_LO    = 3'd1,
    RD_HI    = 3'd2,
    WR_SETUP = 3'd3,
    WR_PULSE = 3'd4,
    WR_HOLD  = 3'd5
  } state_t;

  state_t     state_r, state_nxt_s;
  logic [7:0] idx_r, idx_nxt_s;
  logic [8:0] wr_addr_r, wr_addr_nxt_s;
  logic [7:0] wr_data_r, wr_data_nxt_s;
  logic [7:0] lo_r;
  logic       pend_r, pend_nxt_s;
  logic [7:0] pend_idx_r, pend_idx_nxt_s;
  logic       pend_blank_r, pend_blank_nxt_s;
  logic       overrun_nxt_s;
  logic       blk_d1_r, blk_d2_r;
  logic       take_pend_s, take_pix_s, blk_start_s;
  logic [8:0] addr_nxt_s;
  logic       cen_nxt_s, oen_nxt_s, wen_nxt_s, den_nxt_s;
  logic [7:0] dout_nxt_s;
  logic       unused_s;

  // Bit 7 of the high byte is the palette's don't-care bit.
  assign unused_s = cram_din[7];

  // Next-state: a pending pixel goes first, then a fresh pixel, then a CPU write.
  // The ack cycle blocks re-acceptance of the still-high cpu_req it acknowledges.
  always_comb begin
    state_nxt_s   = state_r;
    idx_nxt_s     = idx_r;
    wr_addr_nxt_s = wr_addr_r;
    wr_data_nxt_s = wr_data_r;
    take_pend_s   = 1'b0;
    take_pix_s    = 1'b0;
    blk_start_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (pend_r) begin
          take_pend_s = 1'b1;
          if (pend_blank_r) begin
            blk_start_s = 1'b1;
          end else begin
            state_nxt_s = RD_LO;
            idx_nxt_s   = pend_idx_r;
          end
        end else if (pix_ce) begin
          take_pix_s = 1'b1;
          if (blank) begin
            blk_start_s = 1'b1;
          end else begin
            state_nxt_s = RD_LO;
            idx_nxt_s   = color_idx;
          end
        end else if (cpu_req && !cpu_ack) begin
          state_nxt_s   = WR_SETUP;
          wr_addr_nxt_s = cpu_addr;
          wr_data_nxt_s = cpu_wdata;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD_LO:    state_nxt_s = RD_HI;
      RD_HI:    state_nxt_s = IDLE;
      WR_SETUP: state_nxt_s = WR_PULSE;
      WR_PULSE: state_nxt_s = WR_HOLD;
      WR_HOLD:  state_nxt_s = IDLE;
      default:  state_nxt_s = IDLE;
    endcase
  end

  // Pending slot: a pixel not taken directly is parked; a full, unfreed slot drops it.
  always_comb begin
    pend_nxt_s       = pend_r;
    pend_idx_nxt_s   = pend_idx_r;
    pend_blank_nxt_s = pend_blank_r;
    overrun_nxt_s    = overrun;
    if (take_pend_s) begin
      pend_nxt_s = 1'b0;
    end else begin
      pend_nxt_s = pend_r;
    end
    if (pix_ce && !take_pix_s) begin
      if (!pend_r || take_pend_s) begin
        pend_nxt_s       = 1'b1;
        pend_idx_nxt_s   = color_idx;
        pend_blank_nxt_s = blank;
      end else begin
        overrun_nxt_s = 1'b1;
      end
    end else begin
      overrun_nxt_s = overrun;
    end
  end

  // RAM strobes for the state being entered, so the pins come straight from flops.
  always_comb begin
    addr_nxt_s = 9'd0;
    cen_nxt_s  = 1'b1;
    oen_nxt_s  = 1'b1;
    wen_nxt_s  = 1'b1;
    den_nxt_s  = 1'b0;
    dout_nxt_s = 8'd0;
    case (state_nxt_s)
      RD_LO: begin
        addr_nxt_s = {idx_nxt_s, 1'b0};
        cen_nxt_s  = 1'b0;
        oen_nxt_s  = 1'b0;
      end
      RD_HI: begin
        addr_nxt_s = {idx_nxt_s, 1'b1};
        cen_nxt_s  = 1'b0;
        oen_nxt_s  = 1'b0;
      end
      WR_SETUP, WR_HOLD: begin
        addr_nxt_s = wr_addr_nxt_s;
        cen_nxt_s  = 1'b0;
        den_nxt_s  = 1'b1;
        dout_nxt_s = wr_data_nxt_s;
      end
      WR_PULSE: begin
        addr_nxt_s = wr_addr_nxt_s;
        cen_nxt_s  = 1'b0;
        wen_nxt_s  = 1'b0;
        den_nxt_s  = 1'b1;
        dout_nxt_s = wr_data_nxt_s;
      end
      default: begin
        addr_nxt_s = 9'd0;
      end
    endcase
  end

  // Control state, request bookkeeping and registered RAM/CPU outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      idx_r        <= 8'd0;
      wr_addr_r    <= 9'd0;
      wr_data_r    <= 8'd0;
      lo_r         <= 8'd0;
      pend_r       <= 1'b0;
      pend_idx_r   <= 8'd0;
      pend_blank_r <= 1'b0;
      overrun      <= 1'b0;
      blk_d1_r     <= 1'b0;
      blk_d2_r     <= 1'b0;
      cpu_ack      <= 1'b0;
      cram_addr    <= 9'd0;
      cram_cen     <= 1'b1;
      cram_oen     <= 1'b1;
      cram_wen     <= 1'b1;
      cram_dout_en <= 1'b0;
      cram_dout    <= 8'd0;
    end else begin
      state_r      <= state_nxt_s;
      idx_r        <= idx_nxt_s;
      wr_addr_r    <= wr_addr_nxt_s;
      wr_data_r    <= wr_data_nxt_s;
      lo_r         <= (state_r == RD_LO) ? cram_din : lo_r;
      pend_r       <= pend_nxt_s;
      pend_idx_r   <= pend_idx_nxt_s;
      pend_blank_r <= pend_blank_nxt_s;
      overrun      <= overrun_nxt_s;
      blk_d1_r     <= blk_start_s;
      blk_d2_r     <= blk_d1_r;
      cpu_ack      <= (state_r == WR_HOLD);
      cram_addr    <= addr_nxt_s;
      cram_cen     <= cen_nxt_s;
      cram_oen     <= oen_nxt_s;
      cram_wen     <= wen_nxt_s;
      cram_dout_en <= den_nxt_s;
      cram_dout    <= dout_nxt_s;
    end
  end

  // Colour output: word is {x, B, G, R}; blank requests emit black on the same timing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_r     <= 5'd0;
      rgb_g     <= 5'd0;
      rgb_b     <= 5'd0;
      rgb_valid <= 1'b0;
    end else if (state_r == RD_HI) begin
      rgb_r     <= lo_r[4:0];
      rgb_g     <= {cram_din[1:0], lo_r[7:5]};
      rgb_b     <= cram_din[6:2];
      rgb_valid <= 1'b1;
    end else if (blk_d2_r) begin
      rgb_r     <= 5'd0;
      rgb_g     <= 5'd0;
      rgb_b     <= 5'd0;
      rgb_valid <= 1'b1;
    end else begin
      rgb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cram_palette_fetch.sv
// Directed bench for cram_palette_fetch: colour RAM model, rgb scoreboard with
// expected arrival cycle, plus inline checks of strobes, ack timing and overrun.
module tb_cram_palette_fetch;

  logic       clk = 1'b0;
  logic       rst, pix_ce, blank, cpu_req, cpu_ack;
  logic [7:0] color_idx, cpu_wdata, cram_din, cram_dout;
  logic [8:0] cpu_addr, cram_addr;
  logic       cram_cen, cram_oen, cram_wen, cram_dout_en;
  logic [4:0] rgb_r, rgb_g, rgb_b;
  logic       rgb_valid, overrun;

  cram_palette_fetch dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .color_idx(color_idx), .blank(blank),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .cram_addr(cram_addr), .cram_cen(cram_cen), .cram_oen(cram_oen), .cram_wen(cram_wen),
    .cram_din(cram_din), .cram_dout(cram_dout), .cram_dout_en(cram_dout_en),
    .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b), .rgb_valid(rgb_valid), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Colour RAM: asynchronous read while selected, write at the clock edge during the pulse.
  logic       mem_init;
  logic [7:0] mem [512];
  assign cram_din = (!cram_cen && !cram_oen) ? mem[cram_addr] : 8'h00;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
      mem[9'h00A] <= 8'h1F;
      mem[9'h00B] <= 8'h7C;
      mem[9'h024] <= 8'hE5;
      mem[9'h025] <= 8'h5A;
    end else if (!cram_cen && !cram_wen && cram_dout_en) begin
      mem[cram_addr] <= cram_dout;
    end
  end

  int n_vec = 0, n_err = 0;
  int cen_low = 0, wen_low = 0, ack_cnt = 0, viol = 0;

  typedef struct { logic [14:0] rgb; int at; } exp_t;
  exp_t sbq[$];

  // Scoreboard monitor: each rgb_valid must match the oldest expectation, value and cycle.
  always @(negedge clk) begin
    if (!rst && rgb_valid) begin
      n_vec++;
      if (sbq.size() == 0) begin
        n_err++;
        $display("FAIL rgb_unexpected actual=%h at cyc %0d, required no output", {rgb_b, rgb_g, rgb_r}, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if ({rgb_b, rgb_g, rgb_r} !== e.rgb || cyc != e.at) begin
          n_err++;
          $display("FAIL rgb actual=%h@%0d required=%h@%0d", {rgb_b, rgb_g, rgb_r}, cyc, e.rgb, e.at);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!cram_cen) cen_low++;
    if (!cram_wen) wen_low++;
    if (cpu_ack) ack_cnt++;
    if ((!cram_oen && !cram_wen) || (!cram_oen && cram_dout_en)) viol++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // lat = cycles from the sampling edge to rgb_valid; 0 means no output is expected.
  task automatic pix(input logic [7:0] idx, input logic blk, input logic [14:0] e, input int lat);
    color_idx = idx;
    blank     = blk;
    pix_ce    = 1'b1;
    if (lat > 0) sbq.push_back('{rgb: e, at: cyc + 1 + lat});
    tick;
    pix_ce = 1'b0;
    blank  = 1'b0;
  endtask

  task automatic wait_wr(output int den_at, output int ack_at);
    den_at = -1;
    ack_at = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cram_dout_en && den_at < 0) den_at = cyc;
      if (cpu_ack) begin
        ack_at = cyc;
        break;
      end
    end
    cpu_req = 1'b0;
    tick;
  endtask

  int k, w0, c0, a0, den_at, ack_at;

  initial begin
    rst = 1'b1; mem_init = 1'b1; pix_ce = 1'b0; blank = 1'b0; color_idx = 8'd0;
    cpu_req = 1'b0; cpu_addr = 9'd0; cpu_wdata = 8'd0;
    repeat (3) tick;
    chk("rst_strobes", {cram_cen, cram_oen, cram_wen, cram_dout_en}, 32'hE);
    chk("rst_addr_dout", {cram_addr, cram_dout}, 32'h0);
    chk("rst_rgb", {rgb_valid, rgb_b, rgb_g, rgb_r}, 32'h0);
    chk("rst_ack_ovr", {cpu_ack, overrun}, 32'h0);
    rst = 1'b0; mem_init = 1'b0;
    repeat (2) tick;

    pix(8'h05, 1'b0, {5'd31, 5'd0, 5'd31}, 2);
    repeat (6) tick;
    pix(8'h12, 1'b0, {5'd22, 5'd23, 5'd5}, 2);
    repeat (6) tick;

    c0 = cen_low;
    pix(8'h05, 1'b1, 15'd0, 2);
    repeat (6) tick;
    chk("blank_no_ram", cen_low - c0, 32'd0);

    // Single CPU write: ack three cycles after WR_SETUP entry, one-cycle write pulse.
    w0 = wen_low; k = cyc;
    cpu_addr = 9'h1FF; cpu_wdata = 8'hA5; cpu_req = 1'b1;
    wait_wr(den_at, ack_at);
    chk("wr_ack_cycle", ack_at, k + 4);
    chk("wr_pulse_len", wen_low - w0, 32'd1);
    chk("wr_mem", mem[9'h1FF], 32'hA5);
    repeat (3) tick;
    pix(8'hFF, 1'b0, {5'd9, 5'd8, 5'd0}, 2);
    repeat (6) tick;

    // Pixel and CPU in the same IDLE cycle: read first, write afterwards.
    k = cyc;
    cpu_addr = 9'h100; cpu_wdata = 8'h3C; cpu_req = 1'b1;
    pix(8'h05, 1'b0, {5'd31, 5'd0, 5'd31}, 2);
    wait_wr(den_at, ack_at);
    chk("prio_wr_entry", den_at, k + 4);
    chk("prio_ack_cycle", ack_at, k + 7);
    chk("prio_wr_mem", mem[9'h100], 32'h3C);
    repeat (4) tick;

    // Pixel during WR_PULSE is parked; a second one before service overruns.
    k = cyc;
    cpu_addr = 9'h050; cpu_wdata = 8'h77; cpu_req = 1'b1;
    tick; tick;
    pix(8'h12, 1'b0, {5'd22, 5'd23, 5'd5}, 4);
    chk("pend_no_ovr", overrun, 32'd0);
    pix(8'h05, 1'b0, 15'd0, 0);
    chk("ovr_set", overrun, 32'd1);
    wait_wr(den_at, ack_at);
    chk("pend_ack_cycle", ack_at, k + 4);
    repeat (8) tick;
    chk("ovr_sticky", overrun, 32'd1);

    // Reset in the middle of the write pulse aborts the write.
    a0 = ack_cnt;
    cpu_addr = 9'h060; cpu_wdata = 8'h99; cpu_req = 1'b1;
    tick; tick;
    chk("pre_rst_wen", cram_wen, 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_mid_strobes", {cram_cen, cram_oen, cram_wen, cram_dout_en}, 32'hE);
    chk("rst_mid_outs", {cpu_ack, overrun, rgb_valid, rgb_b, rgb_g, rgb_r}, 32'h0);
    chk("rst_mid_addr_dout", {cram_addr, cram_dout}, 32'h0);
    cpu_req = 1'b0;
    tick; tick;
    rst = 1'b0;
    repeat (6) tick;
    chk("rst_no_ack", ack_cnt - a0, 32'd0);
    chk("rst_no_write", mem[9'h060], 32'h00);

    pix(8'h12, 1'b0, {5'd22, 5'd23, 5'd5}, 2);
    repeat (8) tick;
    chk("sb_drained", sbq.size(), 32'd0);
    chk("strobe_rules", viol, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
